// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller sitting upstream of the 8-bit PC
// register. It reads the PC, runs the memory-read handshake, latches the returned
// word for the decoder and pulses pc_inc / pc_write_en once per fetched instruction.
// Optional build macro FETCH_TIMEOUT_EN: bounds WAIT to MAX_WAIT not-ready cycles
// and raises a sticky bus_error; without it bus_error is tied low.
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_inc,
  output logic               pc_write_en,
  output logic [ADDR_W-1:0]  pc_datain,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               bus_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    BRANCH = 3'd4
  } state_t;

  state_t state;
  // halt arrived together with a branch: stop after the branch target instruction.
  logic   halt_pending;
  // the branch being taken belongs to that target instruction: stop once it loads.
  logic   branch_stop;
  // stopped by halt: stay in IDLE until run has been seen low.
  logic   halted;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign bus_error = 1'b0;
`endif

  // Sequencer state, handshake outputs and PC controls, all registered.
  // NOTE: every register here uses <= so all reads see pre-edge values; mixing in
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_inc       <= 1'b0;
      pc_write_en  <= 1'b0;
      pc_datain    <= '0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      instr        <= '0;
      instr_valid  <= 1'b0;
      halt_pending <= 1'b0;
      branch_stop  <= 1'b0;
      halted       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      bus_error    <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      // PC controls are single-cycle pulses unless a state re-asserts them.
      pc_inc      <= 1'b0;
      pc_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!run) begin
            halted <= 1'b0;
          end else if (!bus_error && !halted) begin
            state <= REQ;
          end
        end
        REQ: begin
          mem_addr <= pc_value;
          mem_rd   <= 1'b1;
          state    <= WAIT;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mem_ready) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_rd      <= 1'b0;
            pc_inc      <= 1'b1;
            state       <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            bus_error <= 1'b1;
            mem_rd    <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            if (branch_req) begin
              pc_datain    <= branch_target;
              pc_write_en  <= 1'b1;
              branch_stop  <= halt_pending;
              halt_pending <= halt && !halt_pending;
              state        <= BRANCH;
            end else if (halt || halt_pending || !run) begin
              halted       <= halt || halt_pending;
              halt_pending <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= REQ;
            end
          end
        end
        BRANCH: begin
          if (branch_stop) begin
            branch_stop <= 1'b0;
            halted      <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: an environment process models the PC
// register, a memory with programmable latency and a decoder with programmable
// ack delay; a table of single-fetch vectors, hand-written corner sequences and a
// randomized run checked against an address-sequence reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_m = 1'b0;
  logic        rnd_run = 1'b0;
  logic        rnd_on = 1'b0;
  logic        rnd_stop = 1'b0;
  logic        run_sig;
  logic        halt = 1'b0;
  logic [7:0]  pc_value = 8'h00;
  logic        pc_inc, pc_write_en, mem_rd, instr_valid, bus_error;
  logic [7:0]  pc_datain, mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        instr_ack = 1'b0;
  logic        branch_req = 1'b0;
  logic [7:0]  branch_target = 8'h00;

  assign run_sig = rnd_on ? rnd_run : run_m;

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .run(run_sig), .halt(halt), .pc_value(pc_value),
    .pc_inc(pc_inc), .pc_write_en(pc_write_en), .pc_datain(pc_datain),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .branch_req(branch_req), .branch_target(branch_target), .bus_error(bus_error)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Controls written only by the main sequence.
  logic [15:0] mem [256];
  int          mem_lat = 0;
  int          ack_dly = 1;
  logic        dec_branch = 1'b0;
  logic        dec_halt = 1'b0;
  logic [7:0]  dec_target = 8'h00;
  logic        force_ready = 1'b0;
  logic [15:0] force_data = 16'h0000;
  int          pc_set_req = 0;
  logic [7:0]  pc_set_val = 8'h00;

  // State written only by the environment process.
  int          pc_set_seen = 0;
  int          wcnt = 0, hcnt = 0, r_lat = 0, r_ack = 1;
  logic        r_br = 1'b0;
  logic [7:0]  r_tgt = 8'h00;
  logic        s_inc, s_we;
  logic [7:0]  s_din;
  int          c_rd = 0, c_valid = 0, c_inc = 0, c_we = 0, c_overlap = 0;
  int          c_unstable = 0, c_vrise = 0, c_brack = 0;
  logic        prev_rd = 1'b0, prev_valid = 1'b0;
  logic [7:0]  prev_addr = 8'h00, fetch_addr = 8'h00, model_next = 8'h00;

  // Environment: monitor on the falling edge, PC / memory / decoder just after the rising edge.
  initial begin : env
    forever begin
      @(negedge clk);
      s_inc = pc_inc; s_we = pc_write_en; s_din = pc_datain;
      if (mem_rd === 1'b1) c_rd++;
      if (instr_valid === 1'b1) c_valid++;
      if (pc_inc === 1'b1) c_inc++;
      if (pc_write_en === 1'b1) c_we++;
      if (pc_inc === 1'b1 && pc_write_en === 1'b1) c_overlap++;
      if (mem_rd === 1'b1 && prev_rd && mem_addr != prev_addr) c_unstable++;
      if (mem_rd === 1'b1 && !prev_rd) begin
        if (rnd_on) check("rnd_fetch_addr", 32'(mem_addr), 32'(model_next));
        fetch_addr = mem_addr;
      end
      if (instr_valid === 1'b1 && !prev_valid) begin
        c_vrise++;
        if (rnd_on) check("rnd_instr", 32'(instr), 32'(mem[fetch_addr]));
      end
      if (instr_valid === 1'b1 && instr_ack) begin
        model_next = branch_req ? branch_target : fetch_addr + 8'd1;
        if (branch_req) c_brack++;
      end
      prev_rd = (mem_rd === 1'b1); prev_valid = (instr_valid === 1'b1); prev_addr = mem_addr;

      @(posedge clk); #1;
      // PC register: increment wins over load.
      if (pc_set_seen != pc_set_req) begin
        pc_value = pc_set_val; model_next = pc_set_val; pc_set_seen = pc_set_req;
      end else if (s_inc === 1'b1) pc_value = pc_value + 8'd1;
      else if (s_we === 1'b1) pc_value = s_din;
      // Memory: ready after the programmed number of not-ready cycles.
      if (mem_rd === 1'b1) begin
        mem_ready = (wcnt == (rnd_on ? r_lat : mem_lat));
        mem_rdata = mem_ready ? mem[mem_addr] : 16'h0000;
        wcnt++;
      end else begin
        wcnt = 0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        if (rnd_on) r_lat = $urandom_range(0, 3);
      end
      if (force_ready) begin mem_ready = 1'b1; mem_rdata = force_data; end
      // Decoder: ack in the programmed HOLD cycle.
      if (instr_valid === 1'b1) begin
        hcnt++;
        if (hcnt >= (rnd_on ? r_ack : ack_dly)) begin
          instr_ack = 1'b1;
          branch_req = rnd_on ? r_br : dec_branch;
          branch_target = rnd_on ? r_tgt : dec_target;
          halt = rnd_on ? 1'b0 : dec_halt;
        end
      end else begin
        hcnt = 0; instr_ack = 1'b0; branch_req = 1'b0; branch_target = 8'h00; halt = 1'b0;
        if (rnd_on) begin
          r_ack = $urandom_range(1, 4);
          r_br = ($urandom_range(0, 3) == 0);
          r_tgt = 8'($urandom);
        end
      end
      rnd_run = !rnd_stop && ($urandom_range(0, 7) != 0);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; run_m = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set_val = v; pc_set_req++;
    step();
  endtask

  function automatic logic pick(input int which);
    case (which)
      0: return mem_rd;
      1: return instr_valid;
      default: return bus_error;
    endcase
  endfunction

  // Bounded wait; the final comparison reports an expired bound.
  task automatic wait_until(input int which, input logic level, input string name);
    int n = 0;
    while (pick(which) !== level && n < 100) begin step(); n++; end
    check(name, 32'(pick(which)), 32'(level));
  endtask

  typedef struct {
    int lat; int ackd; int br; int tgt; int pc0;
    int exp_lat; int exp_addr; int exp_instr; int exp_rd; int exp_valid;
    int exp_next; int exp_inc; int exp_we; int exp_din;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    int b_rd, b_valid, b_inc, b_we, b_ov, b_un, b_vr, b_br, n;
    logic [7:0] first_addr;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      mem[i] = {a ^ 8'hA5, a};
    end
    mem[0] = 16'h1234;

    //          lat ackd br  tgt   pc0   lat addr  instr     rd valid next  inc we  din
    vecs[0] = '{0,  1,   0,  0,    8'h00, 3, 8'h00, 16'h1234, 1, 1, 8'h01, 1, 0, 8'h00};
    vecs[1] = '{4,  5,   0,  0,    8'h10, 7, 8'h10, 16'hB510, 5, 5, 8'h11, 1, 0, 8'h00};
    vecs[2] = '{0,  1,   1,  8'h40,8'h20, 3, 8'h20, 16'h8520, 1, 1, 8'h40, 1, 1, 8'h40};
    vecs[3] = '{0,  1,   0,  0,    8'hFF, 3, 8'hFF, 16'h5AFF, 1, 1, 8'h00, 1, 0, 8'h00};
    vecs[4] = '{2,  3,   1,  8'hFE,8'h7F, 5, 8'h7F, 16'hDA7F, 3, 3, 8'hFE, 1, 1, 8'hFE};

    // Reset state.
    do_reset();
    check("rst_pc_inc", 32'(pc_inc), 0);
    check("rst_pc_write_en", 32'(pc_write_en), 0);
    check("rst_pc_datain", 32'(pc_datain), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_bus_error", 32'(bus_error), 0);

    // Single-fetch vectors.
    foreach (vecs[k]) begin
      do_reset();
      mem_lat = vecs[k].lat; ack_dly = vecs[k].ackd;
      dec_branch = 1'(vecs[k].br); dec_target = 8'(vecs[k].tgt); dec_halt = 1'b0;
      set_pc(8'(vecs[k].pc0));
      b_rd = c_rd; b_valid = c_valid; b_inc = c_inc; b_we = c_we; b_ov = c_overlap;
      run_m = 1'b1; n = 0; first_addr = 8'hxx;
      while (instr_valid !== 1'b1 && n < 100) begin
        step(); n++;
        if (mem_rd === 1'b1 && n <= 2) first_addr = mem_addr;
      end
      check($sformatf("v%0d_latency", k), n, vecs[k].exp_lat);
      check($sformatf("v%0d_mem_addr", k), 32'(first_addr), vecs[k].exp_addr);
      check($sformatf("v%0d_instr", k), 32'(instr), vecs[k].exp_instr);
      wait_until(0, 1'b1, $sformatf("v%0d_next_fetch", k));
      check($sformatf("v%0d_next_addr", k), 32'(mem_addr), vecs[k].exp_next);
      check($sformatf("v%0d_rd_cycles", k), c_rd - b_rd, vecs[k].exp_rd);
      check($sformatf("v%0d_valid_cycles", k), c_valid - b_valid, vecs[k].exp_valid);
      check($sformatf("v%0d_inc_pulses", k), c_inc - b_inc, vecs[k].exp_inc);
      check($sformatf("v%0d_we_pulses", k), c_we - b_we, vecs[k].exp_we);
      check($sformatf("v%0d_pc_datain", k), 32'(pc_datain), vecs[k].exp_din);
      check($sformatf("v%0d_overlap", k), c_overlap - b_ov, 0);
      run_m = 1'b0;
    end

    // Halt with ack: stays idle while run is held, restarts after run toggles.
    do_reset();
    mem_lat = 0; ack_dly = 1; dec_branch = 1'b0; dec_halt = 1'b1;
    set_pc(8'h30);
    run_m = 1'b1;
    wait_until(1, 1'b1, "halt_valid");
    wait_until(1, 1'b0, "halt_ack");
    b_rd = c_rd;
    repeat (10) step();
    check("halt_no_refetch", c_rd - b_rd, 0);
    dec_halt = 1'b0; run_m = 1'b0;
    step();
    run_m = 1'b1;
    wait_until(0, 1'b1, "halt_restart");
    check("halt_restart_addr", 32'(mem_addr), 32'h31);

    // Halt with branch: honoured after the target instruction.
    do_reset();
    dec_branch = 1'b1; dec_target = 8'h50; dec_halt = 1'b1;
    set_pc(8'h60);
    run_m = 1'b1;
    wait_until(1, 1'b1, "hbr_valid");
    wait_until(1, 1'b0, "hbr_ack");
    dec_branch = 1'b0; dec_halt = 1'b0;
    wait_until(0, 1'b1, "hbr_target_fetch");
    check("hbr_target_addr", 32'(mem_addr), 32'h50);
    wait_until(1, 1'b1, "hbr_target_valid");
    wait_until(1, 1'b0, "hbr_target_ack");
    b_rd = c_rd;
    repeat (10) step();
    check("hbr_stopped", c_rd - b_rd, 0);

    // Reset during WAIT, then a stray mem_ready.
    do_reset();
    mem_lat = 1000;
    set_pc(8'h05);
    run_m = 1'b1;
    wait_until(0, 1'b1, "rw_fetch");
    step(); step();
    reset = 1'b1;
    step();
    check("rw_mem_rd", 32'(mem_rd), 0);
    check("rw_mem_addr", 32'(mem_addr), 0);
    check("rw_instr_valid", 32'(instr_valid), 0);
    check("rw_pc_inc", 32'(pc_inc), 0);
    reset = 1'b0; run_m = 1'b0;
    force_data = 16'hBEEF; force_ready = 1'b1;
    repeat (3) step();
    force_ready = 1'b0;
    check("rw_late_ready_valid", 32'(instr_valid), 0);
    check("rw_late_ready_instr", 32'(instr), 0);

    // Reset during the first HOLD cycle drops pc_inc on the same edge.
    do_reset();
    mem_lat = 0; ack_dly = 5;
    set_pc(8'h09);
    run_m = 1'b1;
    wait_until(1, 1'b1, "rh_valid");
    check("rh_inc_before", 32'(pc_inc), 1);
    reset = 1'b1;
    step();
    check("rh_pc_inc", 32'(pc_inc), 0);
    check("rh_instr_valid", 32'(instr_valid), 0);
    reset = 1'b0;

    // Memory that never answers.
    do_reset();
    mem_lat = 1000; ack_dly = 1;
    set_pc(8'h08);
    run_m = 1'b1;
    wait_until(0, 1'b1, "to_fetch");
    b_rd = c_rd;
`ifdef FETCH_TIMEOUT_EN
    wait_until(2, 1'b1, "to_bus_error");
    check("to_mem_rd", 32'(mem_rd), 0);
    check("to_wait_cycles", c_rd - b_rd, 15);
    b_rd = c_rd;
    repeat (10) step();
    check("to_blocked", c_rd - b_rd, 0);
    check("to_sticky", 32'(bus_error), 1);
    do_reset();
    check("to_reset_clears", 32'(bus_error), 0);
    // Ready on the cycle the limit would be reached completes normally.
    mem_lat = 14;
    run_m = 1'b1;
    wait_until(1, 1'b1, "to_edge_valid");
    check("to_edge_instr", 32'(instr), 32'hAD08);
    check("to_edge_no_error", 32'(bus_error), 0);
`else
    repeat (40) step();
    check("nto_mem_rd", 32'(mem_rd), 1);
    check("nto_wait_cycles", c_rd - b_rd, 40);
    check("nto_bus_error", 32'(bus_error), 0);
`endif

    // Randomized traffic against the address-sequence model.
    do_reset();
    mem_lat = 0;
    set_pc(8'($urandom));
    b_inc = c_inc; b_we = c_we; b_ov = c_overlap; b_un = c_unstable;
    b_vr = c_vrise; b_br = c_brack;
    rnd_stop = 1'b0; rnd_on = 1'b1;
    repeat (800) step();
    rnd_stop = 1'b1;
    repeat (40) step();
    rnd_on = 1'b0;
    check("rnd_inc_per_instr", c_inc - b_inc, c_vrise - b_vr);
    check("rnd_we_per_branch", c_we - b_we, c_brack - b_br);
    check("rnd_overlap", c_overlap - b_ov, 0);
    check("rnd_addr_stable", c_unstable - b_un, 0);
    check("rnd_bus_error", 32'(bus_error), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
